// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) byte helpers for the cipher blocks.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int W_WIDTH    = 128 * (NUM_ROUNDS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } fsm_e;

    // Byte b of each table sits at bits [2047-8*b -: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_inv_09(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul_inv_0b(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul_inv_0d(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul_inv_0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round. Byte i is at [127-8*i -: 8], i = row + 4*col.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] shifted;
    logic [127:0] keyed;
    logic [127:0] mixed;

    // InvShiftRows: row r rotates right by r columns
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8 * (4 * c + r) -: 8] = state_in[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
    end

    // InvSubBytes followed by AddRoundKey
    always_comb begin
        keyed = '0;
        for (int i = 0; i < 16; i++) begin
            keyed[127 - 8 * i -: 8] = inv_sbox(shifted[127 - 8 * i -: 8]) ^ round_key[127 - 8 * i -: 8];
        end
    end

    // InvMixColumns on each column with coefficients {0e,0b,0d,09}
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = keyed[127 - 32 * c -: 8];
            a1 = keyed[119 - 32 * c -: 8];
            a2 = keyed[111 - 32 * c -: 8];
            a3 = keyed[103 - 32 * c -: 8];
            mixed[127 - 32 * c -: 8] = gmul_inv_0e(a0) ^ gmul_inv_0b(a1) ^ gmul_inv_0d(a2) ^ gmul_inv_09(a3);
            mixed[119 - 32 * c -: 8] = gmul_inv_09(a0) ^ gmul_inv_0e(a1) ^ gmul_inv_0b(a2) ^ gmul_inv_0d(a3);
            mixed[111 - 32 * c -: 8] = gmul_inv_0d(a0) ^ gmul_inv_09(a1) ^ gmul_inv_0e(a2) ^ gmul_inv_0b(a3);
            mixed[103 - 32 * c -: 8] = gmul_inv_0b(a0) ^ gmul_inv_0d(a1) ^ gmul_inv_09(a2) ^ gmul_inv_0e(a3);
        end
    end

    assign state_out = last ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock, with trigger/done handshake.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for trigger; loads in ^ rk[10] when it arrives
// ROUND | full inverse round with rk[cnt]; cnt counts 9 down to 1
// FINAL | last round without InvMixColumns, rk[0]; updates out
// DONE  | result stored; returns to IDLE, done pulses the cycle after
module aes_decrypt
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int W_WIDTH    = 128 * (NUM_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W_WIDTH-1:0] w,
    input  logic [127:0]       in,
    output logic [127:0]       out,
    input  logic               trigger,
    output logic               done,
    output logic               busy,
    output logic [127:0]       stateFlat
);

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] state_q, state_d;
    logic [127:0] out_q, out_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic [127:0] rk_sel;
    logic [127:0] round_out;
    logic         last_round;

    // Round key indexed by the counter; counts above NUM_ROUNDS never occur in ROUND/FINAL
    always_comb begin
        rk_sel = '0;
        if (int'(cnt_q) <= NUM_ROUNDS) begin
            rk_sel = w[W_WIDTH - 1 - 128 * int'(cnt_q) -: 128];
        end
    end

    assign last_round = (fsm_q == S_FINAL);

    aes_inv_round u_inv_round (
        .state_in  (state_q),
        .round_key (rk_sel),
        .last      (last_round),
        .state_out (round_out)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm_q <= S_IDLE;
        else        fsm_q <= fsm_d;
    end

    // Datapath, counter and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath update; the last round key rk[NUM_ROUNDS] is w[127:0]
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        out_d   = out_q;
        case (fsm_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = in ^ w[127:0];
                    cnt_d   = 4'(NUM_ROUNDS - 1);
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                case (cnt_q)
                    4'd1: begin
                        state_d = round_out;
                        cnt_d   = cnt_q - 4'd1;
                        fsm_d   = S_FINAL;
                    end
                    4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                        state_d = round_out;
                        cnt_d   = cnt_q - 4'd1;
                    end
                    default: fsm_d = S_IDLE;
                endcase
            end
            S_FINAL: begin
                state_d = round_out;
                out_d   = round_out;
                fsm_d   = S_DONE;
            end
            S_DONE:  fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    // done follows DONE by one cycle; busy covers the accept edge through that done cycle
    always_comb begin
        done_d = (fsm_q == S_DONE);
        busy_d = (fsm_q == S_DONE) || (fsm_d == S_ROUND) || (fsm_d == S_FINAL) || (fsm_d == S_DONE);
    end

    assign out       = out_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign stateFlat = state_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed and round-trip bench for aes_decrypt; key schedule and forward cipher are modelled here.
module tb_aes_decrypt;
    import aes_pkg::*;

    logic          clk;
    logic          rst_n;
    logic [1407:0] w_v;
    logic [127:0]  in_v;
    logic [127:0]  out_v;
    logic          trigger;
    logic          done;
    logic          busy;
    logic [127:0]  state_flat;

    int n_vec = 0;
    int n_bad = 0;

    aes_decrypt dut (
        .clk       (clk),
        .reset     (rst_n),
        .w         (w_v),
        .in        (in_v),
        .out       (out_v),
        .trigger   (trigger),
        .done      (done),
        .busy      (busy),
        .stateFlat (state_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        nm;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs[3];

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   wd[44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] f;
        for (int i = 0; i < 4; i++) wd[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = wd[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = xtime(rc);
            end
            wd[i] = wd[i - 4] ^ t;
        end
        f = '0;
        for (int i = 0; i < 44; i++) f[1407 - 32 * i -: 32] = wd[i];
        return f;
    endfunction

    function automatic logic [127:0] encrypt(input logic [1407:0] wf, input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ wf[1407 -: 128];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[127 - 8 * (4 * c + rr) -: 8] = t[127 - 8 * (4 * ((c + rr) % 4) + rr) -: 8];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32 * c -: 8];
                    a1 = s[119 - 32 * c -: 8];
                    a2 = s[111 - 32 * c -: 8];
                    a3 = s[103 - 32 * c -: 8];
                    s[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            s = s ^ wf[1407 - 128 * r -: 128];
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Start one block and wait (bounded) for done; sf is stateFlat just after the trigger edge.
    task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                             output logic [127:0] pt_got, output int lat, output logic [127:0] sf);
        @(negedge clk);
        w_v     = expand(key);
        in_v    = ct;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        sf  = state_flat;
        lat = -1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                break;
            end
        end
        pt_got = out_v;
    endtask

    logic [127:0] got, sf, key, pt, ct;
    logic [1407:0] wexp;
    int lat, ndone, first, spurious;

    initial begin
        vecs[0] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{"fips_appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{"zero_key", 128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

        rst_n   = 1'b0;
        trigger = 1'b0;
        w_v     = '0;
        in_v    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_out", out_v, 128'd0);
        chk("reset_state", state_flat, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven known-answer vectors
        for (int v = 0; v < 3; v++) begin
            run_block(vecs[v].key, vecs[v].ct, got, lat, sf);
            wexp = expand(vecs[v].key);
            chk({vecs[v].nm, "_out"}, got, vecs[v].pt);
            chk({vecs[v].nm, "_latency"}, 128'(lat), 128'd11);
            chk({vecs[v].nm, "_first_state"}, sf, vecs[v].ct ^ wexp[127:0]);
            @(posedge clk);
            #1;
            chk({vecs[v].nm, "_done_one_cycle"}, 128'(done), 128'd0);
            chk({vecs[v].nm, "_busy_drop"}, 128'(busy), 128'd0);
        end

        // Triggers at k+3 and k+11 with another ciphertext must be ignored
        @(negedge clk);
        w_v = expand(vecs[0].key);
        in_v = vecs[0].ct;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        ndone = 0;
        first = -1;
        got = '0;
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            trigger = (e == 3 || e == 11);
            if (trigger) in_v = vecs[1].ct;
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = e;
                    got = out_v;
                end
            end
            if (e == 12) chk("ignore_busy_drop", 128'(busy), 128'd0);
        end
        trigger = 1'b0;
        chk("ignore_done_count", 128'(ndone), 128'd1);
        chk("ignore_done_edge", 128'(first), 128'd11);
        chk("ignore_out", got, vecs[0].pt);

        // Asynchronous reset in the middle of a block
        @(negedge clk);
        w_v = expand(vecs[1].key);
        in_v = vecs[1].ct;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_done", 128'(done), 128'd0);
        chk("midreset_busy", 128'(busy), 128'd0);
        chk("midreset_out", out_v, 128'd0);
        chk("midreset_state", state_flat, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(vecs[0].key, vecs[0].ct, got, lat, sf);
        chk("after_reset_out", got, vecs[0].pt);
        chk("after_reset_latency", 128'(lat), 128'd11);
        repeat (2) @(posedge clk);

        // Trigger held high, alternating vectors: one result every 12 cycles
        spurious = 0;
        for (int e = 0; e < 48; e++) begin
            @(negedge clk);
            if (e % 12 == 0) begin
                w_v  = expand(vecs[(e / 12) % 2].key);
                in_v = vecs[(e / 12) % 2].ct;
            end
            trigger = 1'b1;
            @(posedge clk);
            #1;
            if (e % 12 == 11) begin
                chk("b2b_done", 128'(done), 128'd1);
                chk("b2b_out", out_v, vecs[(e / 12) % 2].pt);
            end else if (done) begin
                spurious++;
            end
        end
        @(negedge clk);
        trigger = 1'b0;
        chk("b2b_spurious_done", 128'(spurious), 128'd0);
        repeat (14) @(posedge clk);

        // Random round trips through the modelled forward cipher
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            ct  = encrypt(expand(key), pt);
            run_block(key, ct, got, lat, sf);
            chk("roundtrip", got, pt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
